shift_register_param: RTL and testbench



---
 rtl/shift_register_param.sv | 96 +++++++++
 tb/tb_shift_register_param.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/shift_register_param.sv
// Shift/product register with parallel load, SRL/SRA/SLL, last-bit-out flag and saturating step counter.
// 1-cycle latency on every output; no backpressure. SHIFT_REG_DOUBLE_STEP_EN enables amt=1 two-bit steps.
module shift_register_param #(
  parameter int WIDTH     = 64,
  parameter int COUNT_MAX = 32,
  parameter int CNT_W     = $clog2(COUNT_MAX + 1)
) (
  input  logic             clock,
  input  logic             clr,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       mode,
  input  logic             serial_in,
  input  logic             amt,
  output logic [WIDTH-1:0] q,
  output logic             last_out,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SRA  = 2'b10;
  localparam logic [1:0] MODE_SLL  = 2'b11;
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(COUNT_MAX);

  logic             fill_hi;
  logic [WIDTH-1:0] q_nxt;
  logic             last_nxt;
  logic             step;

  // SRA replicates the old sign bit; SRL and SLL take serial_in.
  assign fill_hi = (mode == MODE_SRA) ? q[WIDTH-1] : serial_in;
  assign step    = enable && (mode != MODE_HOLD);

`ifdef SHIFT_REG_DOUBLE_STEP_EN
  always_comb begin
    q_nxt    = q;
    last_nxt = last_out;
    if (mode == MODE_SLL) begin
      if (amt) begin
        q_nxt    = {q[WIDTH-3:0], {2{serial_in}}};
        last_nxt = q[WIDTH-2];
      end else begin
        q_nxt    = {q[WIDTH-2:0], serial_in};
        last_nxt = q[WIDTH-1];
      end
    end else begin
      if (amt) begin
        q_nxt    = {{2{fill_hi}}, q[WIDTH-1:2]};
        last_nxt = q[1];
      end else begin
        q_nxt    = {fill_hi, q[WIDTH-1:1]};
        last_nxt = q[0];
      end
    end
  end
`else
  logic unused_amt;
  assign unused_amt = amt;

  always_comb begin
    q_nxt    = q;
    last_nxt = last_out;
    if (mode == MODE_SLL) begin
      q_nxt    = {q[WIDTH-2:0], serial_in};
      last_nxt = q[WIDTH-1];
    end else begin
      q_nxt    = {fill_hi, q[WIDTH-1:1]};
      last_nxt = q[0];
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (clr) begin
      q        <= '0;
      last_out <= 1'b0;
      count    <= '0;
    end else if (load) begin
      q        <= d;
      last_out <= 1'b0;
      count    <= '0;
    end else if (step) begin
      q        <= q_nxt;
      last_out <= last_nxt;
      // Shifting continues past saturation; only the counter stops.
      if (count != CNT_SAT) begin
        count <= count + 1'b1;
      end
    end
  end

  assign done = (count == CNT_SAT);

endmodule

// File: tb/tb_shift_register_param.sv
// Bench for shift_register_param (WIDTH=8, COUNT_MAX=4): directed scenarios plus randomized
// traffic against an arithmetic reference model.
module tb_shift_register_param;

  localparam int WIDTH     = 8;
  localparam int COUNT_MAX = 4;
  localparam int CNT_W     = $clog2(COUNT_MAX + 1);
`ifdef SHIFT_REG_DOUBLE_STEP_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             clr = 1'b0, enable = 1'b0, load = 1'b0, serial_in = 1'b0, amt = 1'b0;
  logic [WIDTH-1:0] d = '0;
  logic [1:0]       mode = 2'b00;
  logic [WIDTH-1:0] q;
  logic             last_out;
  logic [CNT_W-1:0] count;
  logic             done;
  logic [12:0]      obs;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [WIDTH-1:0] mq;
  logic             mlast;
  int               mcnt;

  shift_register_param #(.WIDTH(WIDTH), .COUNT_MAX(COUNT_MAX)) dut (
    .clock(clock), .clr(clr), .enable(enable), .load(load), .d(d), .mode(mode),
    .serial_in(serial_in), .amt(amt), .q(q), .last_out(last_out), .count(count), .done(done)
  );

  always #5 clock = ~clock;
  assign obs = {q, last_out, count, done};

  function automatic logic [12:0] model_vec();
    return {mq, mlast, 3'(mcnt), (mcnt == COUNT_MAX)};
  endfunction

  // Drives one cycle of stimulus and advances the model, then samples 1 time unit after the edge.
  task automatic cyc(input logic c, input logic l, input logic e, input logic [1:0] m,
                     input logic si, input logic a, input logic [WIDTH-1:0] dd);
    int n;
    logic [WIDTH-1:0] fill;
    clr = c; load = l; enable = e; mode = m; serial_in = si; amt = a; d = dd;
    n = (a && DS) ? 2 : 1;
    fill = si ? ((8'hFF >> (WIDTH - n)) & 8'hFF) : 8'h00;
    if (c) begin
      mq = '0; mlast = 1'b0; mcnt = 0;
    end else if (l) begin
      mq = dd; mlast = 1'b0; mcnt = 0;
    end else if (e && m != 2'b00) begin
      case (m)
        2'b01: begin mlast = mq[n-1]; mq = (mq >> n) | (fill << (WIDTH - n)); end
        2'b10: begin mlast = mq[n-1]; mq = $unsigned($signed(mq) >>> n); end
        default: begin mlast = mq[WIDTH-n]; mq = (mq << n) | fill; end
      endcase
      if (mcnt < COUNT_MAX) mcnt = mcnt + 1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [12:0] exp;
    cyc(1, 0, 0, 2'b00, 0, 0, 8'h00);
    for (int i = 0; i < 6; i++)
      cyc(0, (i == 0), 1, 2'(1 + $urandom_range(0, 2)), 1'($urandom), 1'($urandom), 8'($urandom));
    cyc(1, 0, 1, 2'b01, 1, 0, 8'hFF);
    exp = {8'h00, 1'b0, 3'd0, 1'b0};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL reset: got %h expected %h", obs, exp); end
    cyc(0, 1, 0, 2'b00, 0, 0, 8'hA5);
    exp = {8'hA5, 1'b0, 3'd0, 1'b0};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL load_a5: got %h expected %h", obs, exp); end
  endtask

  task automatic test_sra_srl();
    logic [12:0] exp;
    cyc(0, 1, 0, 2'b00, 0, 0, 8'h81);
    cyc(0, 0, 1, 2'b10, 0, 0, 8'h00);
    exp = {8'hC0, 1'b1, 3'd1, 1'b0};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL sra_81: got %h expected %h", obs, exp); end
    cyc(0, 0, 1, 2'b01, 0, 0, 8'h00);
    exp = {8'h60, 1'b0, 3'd2, 1'b0};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL srl_c0: got %h expected %h", obs, exp); end
  endtask

  task automatic test_sll_hold();
    logic [12:0] exp;
    cyc(0, 1, 0, 2'b00, 0, 0, 8'h81);
    cyc(0, 0, 1, 2'b11, 1, 0, 8'h00);
    exp = {8'h03, 1'b1, 3'd1, 1'b0};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL sll_81: got %h expected %h", obs, exp); end
    cyc(0, 0, 1, 2'b00, 1, 1, 8'hFF);
    cyc(0, 0, 0, 2'b11, 1, 1, 8'hFF);
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL hold: got %h expected %h", obs, exp); end
  endtask

  task automatic test_count_done();
    logic [12:0] exp;
    cyc(0, 1, 0, 2'b00, 0, 0, 8'h10);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 2'b01, 0, 0, 8'h00);
    exp = {8'h02, 1'b0, 3'd3, 1'b0};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL count3: got %h expected %h", obs, exp); end
    cyc(0, 0, 1, 2'b01, 0, 0, 8'h00);
    exp = {8'h01, 1'b0, 3'd4, 1'b1};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL count4_done: got %h expected %h", obs, exp); end
    cyc(0, 0, 1, 2'b01, 0, 0, 8'h00);
    exp = {8'h00, 1'b1, 3'd4, 1'b1};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL saturate: got %h expected %h", obs, exp); end
  endtask

  task automatic test_double_step();
    logic [12:0] exp;
    cyc(0, 1, 0, 2'b00, 0, 0, 8'h8E);
    cyc(0, 0, 1, 2'b10, 0, 1, 8'h00);
    exp = DS ? {8'hE3, 1'b1, 3'd1, 1'b0} : {8'hC7, 1'b0, 3'd1, 1'b0};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL sra_amt1: got %h expected %h", obs, exp); end
    cyc(0, 1, 0, 2'b00, 0, 0, 8'h96);
    cyc(0, 0, 1, 2'b11, 1, 1, 8'h00);
    exp = DS ? {8'h5B, 1'b0, 3'd1, 1'b0} : {8'h2D, 1'b1, 3'd1, 1'b0};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL sll_amt1: got %h expected %h", obs, exp); end
  endtask

  task automatic test_priority();
    logic [12:0] exp;
    cyc(0, 1, 0, 2'b00, 0, 0, 8'hF0);
    cyc(0, 0, 1, 2'b01, 1, 0, 8'h00);
    cyc(0, 1, 1, 2'b01, 1, 0, 8'h3C);
    exp = {8'h3C, 1'b0, 3'd0, 1'b0};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL load_over_shift: got %h expected %h", obs, exp); end
    cyc(0, 0, 1, 2'b01, 1, 0, 8'h00);
    cyc(0, 0, 1, 2'b01, 1, 0, 8'h00);
    exp = {8'hCF, 1'b0, 3'd2, 1'b0};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL pre_clr: got %h expected %h", obs, exp); end
    cyc(1, 1, 1, 2'b01, 1, 0, 8'hAA);
    exp = {8'h00, 1'b0, 3'd0, 1'b0};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL clr_mid_seq: got %h expected %h", obs, exp); end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0), 1'($urandom),
          2'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
      n_checks++;
      if (obs !== model_vec()) begin
        n_fail++;
        if (bad < 10) $display("FAIL random[%0d]: got %h expected %h", i, obs, model_vec());
        bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_sra_srl();
    test_sll_hold();
    test_count_done();
    test_double_step();
    test_priority();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
